// File: rtl/fft_ctrl_pkg.sv
// Shared types and width helpers for the FFT sequencer and its bit-reverse helper.
package fft_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_UNLOAD
    } fft_state_e;

    function automatic int log2n(input int n);
        return $clog2(n);
    endfunction

    function automatic int addr_w(input int n);
        return log2n(n);
    endfunction

    function automatic int tw_w(input int n);
        return log2n(n) - 1;
    endfunction

    function automatic int stage_w(input int n);
        return $clog2(log2n(n)) + 1;
    endfunction

endpackage

// File: rtl/fft_ctrl_bitrev.sv
// Combinational bit-reversal of a W-bit index; usable by the sequencer and by benches.
module fft_bitrev #(
    parameter int W = 10
) (
    input  logic [W-1:0] idx_i,
    output logic [W-1:0] rev_o
);

    always_comb begin
        rev_o = '0;
        for (int i = 0; i < W; i++) begin
            rev_o[i] = idx_i[W-1-i];
        end
    end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT address sequencer: LOAD, COMPUTE/DRAIN per stage, UNLOAD.
// Define FFT_CTRL_BITREV_EN to bit-reverse LOAD write addresses inside the sequencer.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N          = 1024,
    parameter int BF_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    in_valid_i,
    output logic                    ram_rd_en_o,
    output logic [addr_w(N)-1:0]    ram_rd_addr0_o,
    output logic [addr_w(N)-1:0]    ram_rd_addr1_o,
    output logic [1:0]              ram_wr_en_o,
    output logic [addr_w(N)-1:0]    ram_wr_addr0_o,
    output logic [addr_w(N)-1:0]    ram_wr_addr1_o,
    output logic                    ram_wr_sel_o,
    output logic [tw_w(N)-1:0]      twiddle_addr_o,
    output logic [stage_w(N)-1:0]   stage_o,
    output logic                    busy_o,
    output logic                    fft_ready_o,
    output logic                    done_o
);

    localparam int LOG2N  = log2n(N);
    localparam int ADDR_W = addr_w(N);
    localparam int TW_W   = tw_w(N);
    localparam int STG_W  = stage_w(N);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG2N - 1);

    fft_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STG_W-1:0]  stage_q;
    logic              rdv_q;
    logic              done_q;

    logic [BF_LATENCY-1:0] wb_vld_q;
    logic [ADDR_W-1:0]     wb_a0_q [BF_LATENCY];
    logic [ADDR_W-1:0]     wb_a1_q [BF_LATENCY];

    logic [ADDR_W-1:0] b_d, span_d, pos_d, a0_d, a1_d, load_addr_d;
    logic [TW_W-1:0]   tw_d;
    logic              bf_rd_d;

    // Butterfly address generation from the current stage and butterfly index
    always_comb begin
        b_d    = cnt_q[ADDR_W-1:0];
        span_d = ADDR_W'(1) << stage_q;
        pos_d  = b_d & (span_d - ADDR_W'(1));
        a0_d   = ((b_d >> stage_q) << (stage_q + STG_W'(1))) | pos_d;
        a1_d   = a0_d | span_d;
        tw_d   = TW_W'(pos_d) << (LAST_STG - stage_q);
    end

    assign bf_rd_d = (state_q == S_COMPUTE);

`ifdef FFT_CTRL_BITREV_EN
    fft_bitrev #(.W(ADDR_W)) u_bitrev (
        .idx_i (cnt_q[ADDR_W-1:0]),
        .rev_o (load_addr_d)
    );
`else
    assign load_addr_d = cnt_q[ADDR_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            rdv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rdv_q  <= (state_q == S_UNLOAD) && (cnt_q < CNT_W'(N));
            done_q <= (state_q == S_UNLOAD) && (cnt_q == CNT_W'(N - 1));
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                        stage_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid_i) begin
                        if (cnt_q == CNT_W'(N - 1)) begin
                            state_q <= S_COMPUTE;
                            cnt_q   <= '0;
                            stage_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (cnt_q == CNT_W'(N / 2 - 1)) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Leave only once the stage's last write has been issued
                    if (cnt_q == CNT_W'(BF_LATENCY - 1)) begin
                        cnt_q <= '0;
                        if (stage_q == LAST_STG) begin
                            state_q <= S_UNLOAD;
                        end else begin
                            state_q <= S_COMPUTE;
                            stage_q <= stage_q + STG_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_UNLOAD: begin
                    if (cnt_q == CNT_W'(N)) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        stage_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write-back delay line: addresses ride alongside the butterfly pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vld_q <= '0;
        end else begin
            for (int i = BF_LATENCY - 1; i > 0; i--) begin
                wb_vld_q[i] <= wb_vld_q[i-1];
            end
            wb_vld_q[0] <= bf_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = BF_LATENCY - 1; i > 0; i--) begin
            wb_a0_q[i] <= wb_a0_q[i-1];
            wb_a1_q[i] <= wb_a1_q[i-1];
        end
        wb_a0_q[0] <= a0_d;
        wb_a1_q[0] <= a1_d;
    end

    always_comb begin
        ram_rd_en_o    = 1'b0;
        ram_rd_addr0_o = '0;
        ram_rd_addr1_o = '0;
        ram_wr_en_o    = 2'b00;
        ram_wr_addr0_o = '0;
        ram_wr_addr1_o = '0;
        ram_wr_sel_o   = 1'b0;
        twiddle_addr_o = '0;
        unique case (state_q)
            S_LOAD: begin
                if (in_valid_i) begin
                    ram_wr_en_o    = 2'b01;
                    ram_wr_addr0_o = load_addr_d;
                end
            end
            S_COMPUTE: begin
                ram_rd_en_o    = 1'b1;
                ram_rd_addr0_o = a0_d;
                ram_rd_addr1_o = a1_d;
                twiddle_addr_o = tw_d;
            end
            S_UNLOAD: begin
                if (cnt_q < CNT_W'(N)) begin
                    ram_rd_en_o    = 1'b1;
                    ram_rd_addr0_o = cnt_q[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
        if (wb_vld_q[BF_LATENCY-1]) begin
            ram_wr_en_o    = 2'b11;
            ram_wr_sel_o   = 1'b1;
            ram_wr_addr0_o = wb_a0_q[BF_LATENCY-1];
            ram_wr_addr1_o = wb_a1_q[BF_LATENCY-1];
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign stage_o     = stage_q;
    assign fft_ready_o = rdv_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl at N=8, BF_LATENCY=2; LOAD addresses follow FFT_CTRL_BITREV_EN.
module tb_fft_ctrl;

    localparam int N = 8;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst, start_i, in_valid_i;
    logic       ram_rd_en_o, ram_wr_sel_o, busy_o, fft_ready_o, done_o;
    logic [2:0] ram_rd_addr0_o, ram_rd_addr1_o, ram_wr_addr0_o, ram_wr_addr1_o;
    logic [1:0] ram_wr_en_o, twiddle_addr_o;
    logic [2:0] stage_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int brtab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_ctrl #(.N(N), .BF_LATENCY(L)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .in_valid_i     (in_valid_i),
        .ram_rd_en_o    (ram_rd_en_o),
        .ram_rd_addr0_o (ram_rd_addr0_o),
        .ram_rd_addr1_o (ram_rd_addr1_o),
        .ram_wr_en_o    (ram_wr_en_o),
        .ram_wr_addr0_o (ram_wr_addr0_o),
        .ram_wr_addr1_o (ram_wr_addr1_o),
        .ram_wr_sel_o   (ram_wr_sel_o),
        .twiddle_addr_o (twiddle_addr_o),
        .stage_o        (stage_o),
        .busy_o         (busy_o),
        .fft_ready_o    (fft_ready_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {ram_rd_en_o, ram_rd_addr0_o, ram_rd_addr1_o, ram_wr_en_o, ram_wr_addr0_o,
                  ram_wr_addr1_o, ram_wr_sel_o, twiddle_addr_o, stage_o, busy_o,
                  fft_ready_o, done_o}, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction; toggle gaps in_valid_i during LOAD, abort resets in stage 1
    task automatic run(input bit toggle, input bit abort);
        int c0, span, b, a0, bw, w0;
        start_i    = 1'b1;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("start_idle_busy", busy_o, 0);
        c0 = cyc;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid_i = 1'b1;
            @(negedge clk);
            chk("load_wr_en", ram_wr_en_o, 1);
            chk("load_wr_sel", ram_wr_sel_o, 0);
`ifdef FFT_CTRL_BITREV_EN
            chk("load_wr_addr", ram_wr_addr0_o, brtab[k]);
`else
            chk("load_wr_addr", ram_wr_addr0_o, k);
`endif
            chk("load_busy", busy_o, 1);
            chk("load_rd_en", ram_rd_en_o, 0);
            tick();
            if (toggle && k < N - 1) begin
                in_valid_i = 1'b0;
                @(negedge clk);
                chk("load_gap_wr_en", ram_wr_en_o, 0);
                tick();
            end
        end
        in_valid_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            span = 1 << s;
            for (int j = 0; j < N / 2 + L; j++) begin
                start_i = (!toggle && !abort && s == 0);
                @(negedge clk);
                chk("cmp_stage", stage_o, s);
                if (j < N / 2) begin
                    b  = j;
                    a0 = 2 * span * (b / span) + (b % span);
                    chk("cmp_rd_en", ram_rd_en_o, 1);
                    chk("cmp_rd_addr0", ram_rd_addr0_o, a0);
                    chk("cmp_rd_addr1", ram_rd_addr1_o, a0 + span);
                    chk("cmp_twiddle", twiddle_addr_o, (b % span) * (N / 2 / span));
                end else begin
                    chk("drain_rd_en", ram_rd_en_o, 0);
                end
                if (j >= L) begin
                    bw = j - L;
                    w0 = 2 * span * (bw / span) + (bw % span);
                    chk("wb_wr_en", ram_wr_en_o, 3);
                    chk("wb_wr_sel", ram_wr_sel_o, 1);
                    chk("wb_wr_addr0", ram_wr_addr0_o, w0);
                    chk("wb_wr_addr1", ram_wr_addr1_o, w0 + span);
                end else begin
                    chk("wb_wr_en_idle", ram_wr_en_o, 0);
                end
                if (ram_rd_en_o && ram_wr_en_o != 2'b00) begin
                    chk("no_rw_collision",
                        (ram_rd_addr0_o == ram_wr_addr0_o) || (ram_rd_addr0_o == ram_wr_addr1_o) ||
                        (ram_rd_addr1_o == ram_wr_addr0_o) || (ram_rd_addr1_o == ram_wr_addr1_o), 0);
                end
                if (abort && s == 1 && j == 1) begin
                    rst     = 1'b1;
                    start_i = 1'b1;
                    tick();
                    rst     = 1'b0;
                    start_i = 1'b0;
                    @(negedge clk);
                    chk_idle("abort_outputs_zero");
                    tick();
                    @(negedge clk);
                    chk("abort_stays_idle", busy_o, 0);
                    tick();
                    return;
                end
                tick();
            end
        end
        start_i = 1'b0;
        for (int m = 0; m <= N; m++) begin
            @(negedge clk);
            chk("unl_rd_en", ram_rd_en_o, (m < N) ? 1 : 0);
            if (m < N) chk("unl_rd_addr", ram_rd_addr0_o, m);
            chk("unl_ready", fft_ready_o, (m > 0) ? 1 : 0);
            chk("unl_done", done_o, (m == N) ? 1 : 0);
            if (m == N) chk("done_latency", cyc - c0, toggle ? 42 : 35);
            tick();
        end
        @(negedge clk);
        chk("end_busy", busy_o, 0);
        chk("end_ready", fft_ready_o, 0);
        chk("end_done", done_o, 0);
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk_idle("reset_outputs_zero");
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle_outputs_zero");
        tick();
        run(1'b0, 1'b0);
        run(1'b1, 1'b0);
        run(1'b0, 1'b1);
        run(1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
